// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register and single-outstanding instruction-fetch sequencer
// Optional fetch-timeout watchdog is built when PC_SEQ_TIMEOUT_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_valid,
  input  logic [1:0]  jump,
  input  logic [27:0] fjump,
  input  logic [31:0] jumpreg,
  input  logic [31:0] dec_pcadded,
  input  logic        stall,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pcadded,
  output logic        inst_valid,
  output logic        flush,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        misalign,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_pend;
  logic [31:0] r_pend_tgt;
  logic [31:0] r_link_addr;

  logic        w_redirect;
  logic [31:0] w_tgt_raw;
  logic [31:0] w_tgt;
  logic        w_drop;
  logic        w_fetch_live;
  logic        w_ack;
  logic [31:0] w_pc_inc;

  // A jump==0 strobe is a plain sequential instruction and never redirects.
  assign w_redirect = jump_valid && (jump != 2'd0);
  assign w_tgt_raw  = (jump == 2'd2) ? jumpreg : {dec_pcadded[31:28], fjump};
  // Misaligned targets are silently rounded down to the enclosing word.
  assign w_tgt      = {w_tgt_raw[31:2], 2'b00};
  assign w_pc_inc   = r_pc + 32'd4;

  // Request is a decode of the async-reset state flop, so reset drops it at once.
  assign w_fetch_live = (r_state == S_FETCH) && !w_drop;
  assign w_ack        = w_fetch_live && imem_ack;

  assign imem_req   = w_fetch_live;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign pcadded    = w_pc_inc;
  assign inst_valid = w_ack && !w_redirect && !r_pend;
  assign flush      = (w_ack && (w_redirect || r_pend)) ||
                      ((r_state == S_HOLD) && w_redirect);
  assign link_we    = jump_valid && (jump == 2'd3);
  // The link value is visible in the jal cycle itself, then held.
  assign link_addr  = link_we ? dec_pcadded : r_link_addr;
  assign misalign   = w_redirect && (w_tgt_raw[1:0] != 2'b00);

  // Main fetch FSM: PC update, pending-redirect buffer and link capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_VEC;
      r_pend      <= 1'b0;
      r_pend_tgt  <= 32'h0;
      r_link_addr <= 32'h0;
    end else begin
      if (link_we) begin
        r_link_addr <= dec_pcadded;
      end
      case (r_state)
        S_BOOT: begin
          if (w_redirect) begin
            r_pc <= w_tgt;
          end
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (w_ack) begin
            // A redirect arriving with the ack beats an older buffered one.
            if (w_redirect) begin
              r_pc <= w_tgt;
            end else if (r_pend) begin
              r_pc <= r_pend_tgt;
            end else begin
              r_pc <= w_pc_inc;
            end
            r_pend  <= 1'b0;
            r_state <= stall ? S_HOLD : S_FETCH;
          end else if (w_redirect) begin
            // Address must stay stable until ack; remember the newest target.
            r_pend     <= 1'b1;
            r_pend_tgt <= w_tgt;
          end
        end
        S_HOLD: begin
          if (w_redirect) begin
            r_pc <= w_tgt;
          end
          if (!stall) begin
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

`ifdef PC_SEQ_TIMEOUT_EN
  logic [7:0] r_timer;
  logic       r_drop;
  logic       r_fetch_err;

  assign w_drop    = r_drop;
  assign fetch_err = r_fetch_err;

  // Watchdog: count unacknowledged fetch cycles, then drop the request for one cycle and reissue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer     <= 8'd0;
      r_drop      <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (w_fetch_live && !imem_ack) begin
        if (r_timer == 8'(TIMEOUT_CYC - 1)) begin
          r_fetch_err <= 1'b1;
          r_drop      <= 1'b1;
          r_timer     <= 8'd0;
        end else begin
          r_timer <= r_timer + 8'd1;
        end
      end else begin
        r_timer <= 8'd0;
      end
    end
  end
`else
  logic w_unused_cfg;

  assign w_drop       = 1'b0;
  assign fetch_err    = 1'b0;
  assign w_unused_cfg = (TIMEOUT_CYC < 2);
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - vector table plus scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        jump_valid;
  logic [1:0]  jump;
  logic [27:0] fjump;
  logic [31:0] jumpreg;
  logic [31:0] dec_pcadded;
  logic        stall;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pcadded;
  logic        inst_valid;
  logic        flush;
  logic        link_we;
  logic [31:0] link_addr;
  logic        misalign;
  logic        fetch_err;

  int n_pass;
  int n_total;

  typedef struct {
    logic        jv;
    logic [1:0]  jmp;
    logic [27:0] fj;
    logic [31:0] jr;
    logic [31:0] dpc;
    logic        st;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        e_fl;
    logic        e_lwe;
    logic        e_mis;
    logic [31:0] e_link;
  } vec_t;

  typedef struct {
    int          idx;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        e_fl;
    logic        e_lwe;
    logic        e_mis;
    logic [31:0] e_link;
  } exp_t;

  localparam int NV = 28;
  vec_t tbl[NV];
  exp_t sb[$];

  pc_sequencer #(
    .RESET_VEC  (32'h0000_0000),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .jump_valid (jump_valid),
    .jump       (jump),
    .fjump      (fjump),
    .jumpreg    (jumpreg),
    .dec_pcadded(dec_pcadded),
    .stall      (stall),
    .imem_ack   (imem_ack),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .pcadded    (pcadded),
    .inst_valid (inst_valid),
    .flush      (flush),
    .link_we    (link_we),
    .link_addr  (link_addr),
    .misalign   (misalign),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic jv, input logic [1:0] jmp, input logic [27:0] fj,
                              input logic [31:0] jr, input logic [31:0] dpc, input logic st,
                              input logic ack, input logic e_req, input logic [31:0] e_addr,
                              input logic e_iv, input logic e_fl, input logic e_lwe,
                              input logic e_mis, input logic [31:0] e_link);
    vec_t v;
    v.jv = jv; v.jmp = jmp; v.fj = fj; v.jr = jr; v.dpc = dpc; v.st = st; v.ack = ack;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_fl = e_fl;
    v.e_lwe = e_lwe; v.e_mis = e_mis; v.e_link = e_link;
    return v;
  endfunction

  task automatic drive_idle(input logic ack, input logic st);
    jump_valid  = 1'b0;
    jump        = 2'd0;
    fjump       = 28'h0;
    jumpreg     = 32'h0;
    dec_pcadded = 32'h0;
    stall       = st;
    imem_ack    = ack;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    //         jv jmp fj          jr            dpc           st ack  req addr          iv fl lwe mis link
    tbl[0]  = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 0,   0, 32'h0,         0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 1,   1, 32'h0,         1, 0, 0, 0, 32'h0);
    tbl[2]  = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 1,   1, 32'h4,         1, 0, 0, 0, 32'h0);
    tbl[3]  = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 1,   1, 32'h8,         1, 0, 0, 0, 32'h0);
    tbl[4]  = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 1,   1, 32'hC,         1, 0, 0, 0, 32'h0);
    tbl[5]  = mk(1, 1, 28'h40,    32'h0,        32'h1000_0008,0, 1,   1, 32'h10,        0, 1, 0, 0, 32'h0);
    tbl[6]  = mk(1, 2, 28'h0,     32'h2000,     32'h0,        0, 0,   1, 32'h1000_0040, 0, 0, 0, 0, 32'h0);
    tbl[7]  = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 0,   1, 32'h1000_0040, 0, 0, 0, 0, 32'h0);
    tbl[8]  = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 1,   1, 32'h1000_0040, 0, 1, 0, 0, 32'h0);
    tbl[9]  = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 1,   1, 32'h2000,      1, 0, 0, 0, 32'h0);
    tbl[10] = mk(1, 3, 28'h800,   32'h0,        32'h14,       0, 1,   1, 32'h2004,      0, 1, 1, 0, 32'h14);
    tbl[11] = mk(1, 2, 28'h0,     32'h103,      32'h0,        0, 1,   1, 32'h800,       0, 1, 0, 1, 32'h14);
    tbl[12] = mk(0, 0, 28'h0,     32'h0,        32'h0,        1, 1,   1, 32'h100,       1, 0, 0, 0, 32'h14);
    tbl[13] = mk(0, 0, 28'h0,     32'h0,        32'h0,        1, 0,   0, 32'h104,       0, 0, 0, 0, 32'h14);
    tbl[14] = mk(1, 2, 28'h0,     32'h3000,     32'h0,        1, 0,   0, 32'h104,       0, 1, 0, 0, 32'h14);
    tbl[15] = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 0,   0, 32'h3000,      0, 0, 0, 0, 32'h14);
    tbl[16] = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 1,   1, 32'h3000,      1, 0, 0, 0, 32'h14);
    tbl[17] = mk(1, 0, 28'h0,     32'h5000,     32'h0,        0, 1,   1, 32'h3004,      1, 0, 0, 0, 32'h14);
    tbl[18] = mk(1, 1, 28'h10,    32'h0,        32'h0,        0, 0,   1, 32'h3008,      0, 0, 0, 0, 32'h14);
    tbl[19] = mk(1, 2, 28'h0,     32'h20,       32'h0,        0, 0,   1, 32'h3008,      0, 0, 0, 0, 32'h14);
    tbl[20] = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 1,   1, 32'h3008,      0, 1, 0, 0, 32'h14);
    tbl[21] = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 1,   1, 32'h20,        1, 0, 0, 0, 32'h14);
    tbl[22] = mk(1, 2, 28'h0,     32'h40,       32'h0,        0, 0,   1, 32'h24,        0, 0, 0, 0, 32'h14);
    tbl[23] = mk(1, 2, 28'h0,     32'h60,       32'h0,        0, 1,   1, 32'h24,        0, 1, 0, 0, 32'h14);
    tbl[24] = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 1,   1, 32'h60,        1, 0, 0, 0, 32'h14);
    tbl[25] = mk(1, 2, 28'h0,     32'hFFFF_FFFC,32'h0,        0, 1,   1, 32'h64,        0, 1, 0, 0, 32'h14);
    tbl[26] = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 1,   1, 32'hFFFF_FFFC, 1, 0, 0, 0, 32'h14);
    tbl[27] = mk(0, 0, 28'h0,     32'h0,        32'h0,        0, 0,   1, 32'h0,         0, 0, 0, 0, 32'h14);

    // Reset state
    rst_n = 1'b0;
    drive_idle(1'b0, 1'b0);
    #2;
    chk("rst_req",       {31'h0, imem_req},   32'h0);
    chk("rst_pc",        pc,                  32'h0);
    chk("rst_iv",        {31'h0, inst_valid}, 32'h0);
    chk("rst_flush",     {31'h0, flush},      32'h0);
    chk("rst_link_addr", link_addr,           32'h0);
    chk("rst_fetch_err", {31'h0, fetch_err},  32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Table: drive at negedge, push expectation, sample mid-low phase and compare against popped entry
    for (int i = 0; i < NV; i++) begin
      exp_t e;
      exp_t g;
      @(negedge clk);
      jump_valid  = tbl[i].jv;
      jump        = tbl[i].jmp;
      fjump       = tbl[i].fj;
      jumpreg     = tbl[i].jr;
      dec_pcadded = tbl[i].dpc;
      stall       = tbl[i].st;
      imem_ack    = tbl[i].ack;
      e.idx = i; e.e_req = tbl[i].e_req; e.e_addr = tbl[i].e_addr; e.e_iv = tbl[i].e_iv;
      e.e_fl = tbl[i].e_fl; e.e_lwe = tbl[i].e_lwe; e.e_mis = tbl[i].e_mis; e.e_link = tbl[i].e_link;
      sb.push_back(e);
      #2;
      g = sb.pop_front();
      chk($sformatf("r%0d_req", g.idx),     {31'h0, imem_req},   {31'h0, g.e_req});
      chk($sformatf("r%0d_addr", g.idx),    imem_addr,           g.e_addr);
      chk($sformatf("r%0d_pcadded", g.idx), pcadded,             g.e_addr + 32'd4);
      chk($sformatf("r%0d_iv", g.idx),      {31'h0, inst_valid}, {31'h0, g.e_iv});
      chk($sformatf("r%0d_flush", g.idx),   {31'h0, flush},      {31'h0, g.e_fl});
      chk($sformatf("r%0d_link_we", g.idx), {31'h0, link_we},    {31'h0, g.e_lwe});
      chk($sformatf("r%0d_misalign", g.idx),{31'h0, misalign},   {31'h0, g.e_mis});
      chk($sformatf("r%0d_link", g.idx),    link_addr,           g.e_link);
      chk($sformatf("r%0d_ferr", g.idx),    {31'h0, fetch_err},  32'h0);
    end
    chk("sb_empty", sb.size(), 32'd0);

    // No-ack run: three more unanswered fetch cycles (four in total with the last table row)
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_idle(1'b0, 1'b0);
      #2;
      chk($sformatf("to%0d_req", k),  {31'h0, imem_req},  32'h1);
      chk($sformatf("to%0d_addr", k), imem_addr,          32'h0);
      chk($sformatf("to%0d_ferr", k), {31'h0, fetch_err}, 32'h0);
    end
    @(negedge clk);
    drive_idle(1'b0, 1'b0);
    #2;
`ifdef PC_SEQ_TIMEOUT_EN
    chk("to_drop_req",  {31'h0, imem_req},  32'h0);
    chk("to_drop_ferr", {31'h0, fetch_err}, 32'h1);
`else
    chk("to_wait_req",  {31'h0, imem_req},  32'h1);
    chk("to_wait_ferr", {31'h0, fetch_err}, 32'h0);
`endif
    @(negedge clk);
    drive_idle(1'b0, 1'b0);
    #2;
    chk("to_reissue_req",  {31'h0, imem_req}, 32'h1);
    chk("to_reissue_addr", imem_addr,         32'h0);
`ifdef PC_SEQ_TIMEOUT_EN
    chk("to_sticky_ferr", {31'h0, fetch_err}, 32'h1);
`else
    chk("to_sticky_ferr", {31'h0, fetch_err}, 32'h0);
`endif

    // Async reset during an outstanding fetch after moving the PC away from the reset vector
    @(negedge clk);
    drive_idle(1'b1, 1'b0);
    #2;
    chk("pre_rst_iv", {31'h0, inst_valid}, 32'h1);
    @(negedge clk);
    drive_idle(1'b0, 1'b0);
    #2;
    chk("pre_rst_addr", imem_addr, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'h0, imem_req}, 32'h0);
    chk("async_rst_pc",  pc,                32'h0);
    chk("async_rst_ferr",{31'h0, fetch_err}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("boot_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    #2;
    chk("boot_fetch_req",  {31'h0, imem_req}, 32'h1);
    chk("boot_fetch_addr", imem_addr,         32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
